// File: rtl/core_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM encoding,
// the control-word bundle and its idle value.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DIV   = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  typedef struct packed {
    logic if_stall;
    logic id_stall;
    logic ex_bubble;
    logic if_flush;
    logic id_flush;
    logic ex_flush;
    logic mem_flush;
    logic div_busy;
    logic div_done;
    logic div_cancel;
    logic pc_redirect;
    logic int_ack;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_NOP = '0;

  function automatic logic any_flush(
    input ctrl_out_t c
  );
    return c.if_flush | c.id_flush |
           c.ex_flush | c.mem_flush;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stall/flush/redirect controls
// between the pipeline datapath and pipe_ctrl.
interface pipe_ctrl_if;

  logic        load_use_hazard;
  logic        mfc0_in_id;
  logic        mtc0_in_ex;
  logic        mtc0_in_mem;
  logic        div_start;
  logic        exc_req;
  logic [31:0] exc_target;
  logic        int_req;

  logic        if_stall;
  logic        id_stall;
  logic        ex_bubble;
  logic        if_flush;
  logic        id_flush;
  logic        ex_flush;
  logic        mem_flush;
  logic        div_busy;
  logic        div_done;
  logic        div_cancel;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        int_ack;
  logic [1:0]  ctrl_state;

  modport master (
    output load_use_hazard, mfc0_in_id,
    output mtc0_in_ex, mtc0_in_mem,
    output div_start, exc_req,
    output exc_target, int_req,
    input  if_stall, id_stall, ex_bubble,
    input  if_flush, id_flush,
    input  ex_flush, mem_flush,
    input  div_busy, div_done, div_cancel,
    input  pc_redirect, redirect_pc,
    input  int_ack, ctrl_state
  );

  modport slave (
    input  load_use_hazard, mfc0_in_id,
    input  mtc0_in_ex, mtc0_in_mem,
    input  div_start, exc_req,
    input  exc_target, int_req,
    output if_stall, id_stall, ex_bubble,
    output if_flush, id_flush,
    output ex_flush, mem_flush,
    output div_busy, div_done, div_cancel,
    output pc_redirect, redirect_pc,
    output int_ack, ctrl_state
  );

endinterface

// File: rtl/pipe_ctrl_div_seq_cnt.sv
// Loadable 6-bit down-counter with zero flag that
// paces the multi-cycle divide.
module div_seq_cnt (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [5:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 6'd0);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline scheduler: hazard stalls, divide
// sequencing and precise exception/interrupt flushes.
module pipe_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR =
    EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  pipe_ctrl_if.slave  bus
);

  localparam logic [5:0] DIV_LOAD =
    6'(DIV_CYCLES - 1);

  ctrl_state_e state_q, state_d;
  logic        int_pend_q, int_pend_d;
  logic        int_ack_q, int_ack_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic      cnt_load;
  logic      cnt_dec;
  logic      cnt_zero;
  logic      hazard;
  ctrl_out_t out_c;

  div_seq_cnt u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (DIV_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign hazard = bus.load_use_hazard |
    (bus.mfc0_in_id &
     (bus.mtc0_in_ex | bus.mtc0_in_mem));

  always_comb begin
    state_d       = state_q;
    int_pend_d    = int_pend_q;
    int_ack_d     = 1'b0;
    redirect_pc_d = redirect_pc_q;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    out_c         = CTRL_NOP;

    unique case (state_q)
      ST_RUN: begin
        if (bus.exc_req) begin
          out_c.if_flush  = 1'b1;
          out_c.id_flush  = 1'b1;
          out_c.ex_flush  = 1'b1;
          out_c.mem_flush = 1'b1;
          redirect_pc_d   = bus.exc_target;
          state_d         = ST_FLUSH;
        end else if (bus.int_req) begin
          out_c.if_flush = 1'b1;
          out_c.id_flush = 1'b1;
          out_c.ex_flush = 1'b1;
          out_c.int_ack  = 1'b1;
          redirect_pc_d  = EXC_VECTOR;
          state_d        = ST_FLUSH;
        end else if (bus.div_start) begin
          cnt_load = 1'b1;
          state_d  = ST_DIV;
        end else begin
          out_c.if_stall  = hazard;
          out_c.id_stall  = hazard;
          out_c.ex_bubble = hazard;
        end
      end

      ST_DIV: begin
        out_c.div_busy = 1'b1;
        out_c.if_stall = 1'b1;
        out_c.id_stall = 1'b1;
        cnt_dec        = ~cnt_zero;
        if (bus.exc_req) begin
          out_c.div_cancel = 1'b1;
          out_c.if_flush   = 1'b1;
          out_c.id_flush   = 1'b1;
          out_c.ex_flush   = 1'b1;
          out_c.mem_flush  = 1'b1;
          redirect_pc_d    = bus.exc_target;
          int_pend_d       = 1'b0;
          state_d          = ST_FLUSH;
        end else if (cnt_zero) begin
          out_c.div_done = 1'b1;
          int_pend_d     = 1'b0;
          // interrupts held off by the divide are taken now
          if (int_pend_q | bus.int_req) begin
            redirect_pc_d = EXC_VECTOR;
            int_ack_d     = 1'b1;
            state_d       = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else if (bus.int_req) begin
          int_pend_d = 1'b1;
        end
      end

      ST_FLUSH: begin
        out_c.pc_redirect = 1'b1;
        out_c.if_flush    = 1'b1;
        out_c.int_ack     = int_ack_q;
        state_d           = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (any_flush(out_c)) begin
      out_c.if_stall  = 1'b0;
      out_c.id_stall  = 1'b0;
      out_c.ex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_RUN;
      int_pend_q    <= 1'b0;
      int_ack_q     <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      int_pend_q    <= int_pend_d;
      int_ack_q     <= int_ack_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // reset must silence even the combinational controls
  assign bus.if_stall    = resetn & out_c.if_stall;
  assign bus.id_stall    = resetn & out_c.id_stall;
  assign bus.ex_bubble   = resetn & out_c.ex_bubble;
  assign bus.if_flush    = resetn & out_c.if_flush;
  assign bus.id_flush    = resetn & out_c.id_flush;
  assign bus.ex_flush    = resetn & out_c.ex_flush;
  assign bus.mem_flush   = resetn & out_c.mem_flush;
  assign bus.div_busy    = resetn & out_c.div_busy;
  assign bus.div_done    = resetn & out_c.div_done;
  assign bus.div_cancel  = resetn & out_c.div_cancel;
  assign bus.pc_redirect = resetn & out_c.pc_redirect;
  assign bus.int_ack     = resetn & out_c.int_ack;
  assign bus.redirect_pc =
    resetn ? redirect_pc_q : 32'd0;
  assign bus.ctrl_state  =
    resetn ? 2'(state_q) : 2'd0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed cycles push
// expected control words, a negedge monitor checks them.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .DIV_CYCLES (4),
    .EXC_VECTOR (32'hBFC0_0380)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // input word: resetn lu mfc0 mex mmem ds exc irq
  localparam logic [7:0] I_RST = 8'h00;
  localparam logic [7:0] I_ID  = 8'h80;
  localparam logic [7:0] LU    = 8'h40;
  localparam logic [7:0] MFC   = 8'h20;
  localparam logic [7:0] MEX   = 8'h10;
  localparam logic [7:0] MMEM  = 8'h08;
  localparam logic [7:0] DS    = 8'h04;
  localparam logic [7:0] EXC   = 8'h02;
  localparam logic [7:0] IRQ   = 8'h01;

  // output word, msb first: if_stall id_stall ex_bubble
  // if/id/ex/mem flush, busy done cancel redirect ack
  localparam logic [11:0] O0   = 12'h000;
  localparam logic [11:0] STL  = 12'hE00;
  localparam logic [11:0] DSTL = 12'hC00;
  localparam logic [11:0] F3   = 12'h1C0;
  localparam logic [11:0] F4   = 12'h1E0;
  localparam logic [11:0] FIF  = 12'h100;
  localparam logic [11:0] BUSY = 12'h010;
  localparam logic [11:0] DONE = 12'h008;
  localparam logic [11:0] CANC = 12'h004;
  localparam logic [11:0] PCR  = 12'h002;
  localparam logic [11:0] ACK  = 12'h001;

  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam logic [31:0] T1   = 32'h8000_0180;
  localparam logic [31:0] T2   = 32'h8000_0200;
  localparam logic [31:0] T3   = 32'h0000_1234;

  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] DV  = 2'd1;
  localparam logic [1:0] FL  = 2'd2;

  typedef struct packed {
    logic [11:0] o;
    logic [31:0] pc;
    logic [1:0]  st;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic cyc(
    input string       nm,
    input logic [7:0]  iv,
    input logic [31:0] tgt,
    input logic [11:0] eo,
    input logic [31:0] epc,
    input logic [1:0]  est
  );
    exp_t e;
    @(posedge clk);
    #1;
    resetn              = iv[7];
    bus.load_use_hazard = iv[6];
    bus.mfc0_in_id      = iv[5];
    bus.mtc0_in_ex      = iv[4];
    bus.mtc0_in_mem     = iv[3];
    bus.div_start       = iv[2];
    bus.exc_req         = iv[1];
    bus.int_req         = iv[0];
    bus.exc_target      = tgt;
    e.o  = eo;
    e.pc = epc;
    e.st = est;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    string       nm;
    logic [11:0] ao;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      ao = {bus.if_stall, bus.id_stall,
            bus.ex_bubble, bus.if_flush,
            bus.id_flush, bus.ex_flush,
            bus.mem_flush, bus.div_busy,
            bus.div_done, bus.div_cancel,
            bus.pc_redirect, bus.int_ack};
      checks++;
      if (ao !== e.o || bus.redirect_pc !== e.pc ||
          bus.ctrl_state !== e.st) begin
        errors++;
        $display(
          "FAIL %s: got o=%03h pc=%08h st=%0d want o=%03h pc=%08h st=%0d",
          nm, ao, bus.redirect_pc, bus.ctrl_state,
          e.o, e.pc, e.st);
      end
    end
  end

  initial begin
    resetn              = 1'b0;
    bus.load_use_hazard = 1'b0;
    bus.mfc0_in_id      = 1'b0;
    bus.mtc0_in_ex      = 1'b0;
    bus.mtc0_in_mem     = 1'b0;
    bus.div_start       = 1'b0;
    bus.exc_req         = 1'b0;
    bus.int_req         = 1'b0;
    bus.exc_target      = '0;

    cyc("rst0", I_RST, 0, O0, 0, RUN);
    cyc("rst1", I_RST, 0, O0, 0, RUN);
    cyc("idle", I_ID, 0, O0, 0, RUN);

    cyc("lu", I_ID|LU, 0, STL, 0, RUN);
    cyc("lu_rel", I_ID, 0, O0, 0, RUN);
    cyc("cp0_ex", I_ID|MFC|MEX, 0, STL, 0, RUN);
    cyc("cp0_mem", I_ID|MFC|MMEM, 0, STL, 0, RUN);
    cyc("cp0_rel", I_ID|MFC, 0, O0, 0, RUN);
    cyc("mtc0_only", I_ID|MEX|MMEM, 0, O0, 0, RUN);

    cyc("div_t0", I_ID|DS, 0, O0, 0, RUN);
    cyc("div_t1", I_ID, 0, DSTL|BUSY, 0, DV);
    cyc("div_t2_ds", I_ID|DS, 0, DSTL|BUSY, 0, DV);
    cyc("div_t3_lu", I_ID|LU, 0, DSTL|BUSY, 0, DV);
    cyc("div_t4", I_ID, 0, DSTL|BUSY|DONE, 0, DV);
    cyc("div_t5", I_ID, 0, O0, 0, RUN);

    cyc("dint_t0", I_ID|DS, 0, O0, 0, RUN);
    cyc("dint_t1", I_ID, 0, DSTL|BUSY, 0, DV);
    cyc("dint_t2", I_ID|IRQ, 0, DSTL|BUSY, 0, DV);
    cyc("dint_t3", I_ID, 0, DSTL|BUSY, 0, DV);
    cyc("dint_t4", I_ID, 0, DSTL|BUSY|DONE, 0, DV);
    cyc("dint_t5", I_ID, 0, FIF|PCR|ACK, VEC, FL);
    cyc("dint_t6", I_ID, 0, O0, VEC, RUN);

    cyc("dexc_t0", I_ID|DS, 0, O0, VEC, RUN);
    cyc("dexc_t1", I_ID, 0, DSTL|BUSY, VEC, DV);
    cyc("dexc_t2", I_ID|EXC, T1,
        F4|BUSY|CANC, VEC, DV);
    cyc("dexc_t3", I_ID, 0, FIF|PCR, T1, FL);
    cyc("dexc_t4", I_ID, 0, O0, T1, RUN);

    cyc("dez_t0", I_ID|DS, 0, O0, T1, RUN);
    cyc("dez_t1", I_ID, 0, DSTL|BUSY, T1, DV);
    cyc("dez_t2", I_ID, 0, DSTL|BUSY, T1, DV);
    cyc("dez_t3", I_ID, 0, DSTL|BUSY, T1, DV);
    cyc("dez_t4", I_ID|EXC|IRQ, T2,
        F4|BUSY|CANC, T1, DV);
    cyc("dez_t5", I_ID, 0, FIF|PCR, T2, FL);
    cyc("dez_t6", I_ID, 0, O0, T2, RUN);

    cyc("diz_t0", I_ID|DS, 0, O0, T2, RUN);
    cyc("diz_t1", I_ID, 0, DSTL|BUSY, T2, DV);
    cyc("diz_t2", I_ID, 0, DSTL|BUSY, T2, DV);
    cyc("diz_t3", I_ID, 0, DSTL|BUSY, T2, DV);
    cyc("diz_t4", I_ID|IRQ, 0,
        DSTL|BUSY|DONE, T2, DV);
    cyc("diz_t5", I_ID, 0, FIF|PCR|ACK, VEC, FL);
    cyc("diz_t6", I_ID, 0, O0, VEC, RUN);

    cyc("exint", I_ID|EXC|IRQ|LU, T1, F4, VEC, RUN);
    cyc("exint_fl", I_ID|IRQ|LU|DS, 0,
        FIF|PCR, T1, FL);
    cyc("int_run", I_ID|IRQ|LU, 0, F3|ACK, T1, RUN);
    cyc("int_fl", I_ID, 0, FIF|PCR, VEC, FL);
    cyc("int_done", I_ID, 0, O0, VEC, RUN);

    cyc("rfl_exc", I_ID|EXC, T3, F4, VEC, RUN);
    cyc("rfl_rst", I_RST|LU|IRQ, 0, O0, 0, RUN);
    cyc("rfl_after", I_ID, 0, O0, 0, RUN);

    cyc("rdv_t0", I_ID|DS, 0, O0, 0, RUN);
    cyc("rdv_t1", I_ID, 0, DSTL|BUSY, 0, DV);
    cyc("rdv_rst", I_RST|EXC, T3, O0, 0, RUN);
    cyc("rdv_after", I_ID, 0, O0, 0, RUN);
    cyc("rdv_idle", I_ID, 0, O0, 0, RUN);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
